// File: rtl/mbist_pkg.sv
// rtl/mbist_pkg.sv - shared MBIST types for address sequencing and March control
package mbist_pkg;

    typedef enum logic [1:0] {
        ORD_LINEAR,
        ORD_GRAY,
        ORD_ROWFAST,
        ORD_RSVD
    } addr_order_e;

    typedef enum logic [1:0] {
        AG_IDLE,
        AG_RUN
    } ag_state_e;

endpackage

// File: rtl/mbist_addr_map.sv
// rtl/mbist_addr_map.sv - combinational counter-to-address ordering map
//
// Ports:
//   cnt_i  [ADDR_W] linear sequence count
//   mode_i          ordering: linear, Gray, row-fast (reserved maps as linear)
//   addr_o [ADDR_W] mapped memory address
module mbist_addr_map
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int ROW_W  = 5
) (
    input  logic [ADDR_W-1:0] cnt_i,
    input  addr_order_e       mode_i,
    output logic [ADDR_W-1:0] addr_o
);

    always_comb begin
        addr_o = cnt_i;
        case (mode_i)
            ORD_GRAY:    addr_o = cnt_i ^ (cnt_i >> 1);
            // Rotate left by ROW_W so the low count bits drive the row field.
            ORD_ROWFAST: addr_o = {cnt_i[ADDR_W-ROW_W-1:0], cnt_i[ADDR_W-1:ADDR_W-ROW_W]};
            default:     addr_o = cnt_i;
        endcase
    end

endmodule

// File: rtl/mbist_addr_gen.sv
// rtl/mbist_addr_gen.sv - bounded MBIST address sequencer with start/advance/done handshake
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort, adv sequence control from the March controller
//   dir, mode, lo, hi configuration, sampled on start
//   addr              registered mapped address
//   busy, last        sequence active / current count is terminal
//   done, cout        one-cycle pulses on completion / full-range terminal count
//   err               sticky configuration error
module mbist_addr_gen
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int ROW_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              adv,
    input  logic              dir,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] lo,
    input  logic [ADDR_W-1:0] hi,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              last,
    output logic              done,
    output logic              cout,
    output logic              err
);

    ag_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] lo_q, lo_d;
    logic [ADDR_W-1:0] hi_q, hi_d;
    logic              dir_q, dir_d;
    addr_order_e       mode_q, mode_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              cout_q, cout_d;
    logic              addr_load;
    logic              last_w;
    logic [ADDR_W-1:0] map_w;

    // Terminal detection always uses the internal count, never the mapped address.
    assign last_w = (state_q == AG_RUN) && (dir_q ? (cnt_q == hi_q) : (cnt_q == lo_q));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        err_d     = err_q;
        done_d    = 1'b0;
        cout_d    = 1'b0;
        addr_load = 1'b0;
        if (abort) begin
            state_d = AG_IDLE;
        end else if (start) begin
            lo_d   = lo;
            hi_d   = hi;
            dir_d  = dir;
            mode_d = addr_order_e'(mode);
            if ((lo > hi) || (addr_order_e'(mode) == ORD_RSVD)) begin
                // Bad config leaves the count and address untouched.
                err_d   = 1'b1;
                state_d = AG_IDLE;
            end else begin
                err_d     = 1'b0;
                cnt_d     = dir ? lo : hi;
                addr_load = 1'b1;
                state_d   = AG_RUN;
            end
        end else if ((state_q == AG_RUN) && adv) begin
            if (last_w) begin
                done_d  = 1'b1;
                cout_d  = dir_q ? (&cnt_q) : ~(|cnt_q);
                state_d = AG_IDLE;
            end else begin
                cnt_d     = dir_q ? cnt_q + ADDR_W'(1) : cnt_q - ADDR_W'(1);
                addr_load = 1'b1;
            end
        end
        addr_d = addr_load ? map_w : addr_q;
    end

    // Map the next count so addr and cnt update on the same edge.
    mbist_addr_map #(
        .ADDR_W (ADDR_W),
        .ROW_W  (ROW_W)
    ) u_map (
        .cnt_i  (cnt_d),
        .mode_i (mode_d),
        .addr_o (map_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= AG_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            dir_q   <= 1'b1;
            mode_q  <= ORD_LINEAR;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
        end
    end

    assign addr = addr_q;
    assign busy = (state_q == AG_RUN);
    assign last = last_w;
    assign done = done_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_mbist_addr_gen.sv
// tb/tb_mbist_addr_gen.sv - directed self-checking bench for mbist_addr_gen
module tb_mbist_addr_gen;

    localparam int ADDR_W = 10;
    localparam int ROW_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, abort, adv, dir;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] lo, hi;
    logic [ADDR_W-1:0] addr;
    logic              busy, last, done, cout, err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mbist_addr_gen #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .adv   (adv),
        .dir   (dir),
        .mode  (mode),
        .lo    (lo),
        .hi    (hi),
        .addr  (addr),
        .busy  (busy),
        .last  (last),
        .done  (done),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] l, input logic [ADDR_W-1:0] h,
                            input logic d, input logic [1:0] m, input logic with_adv);
        lo = l; hi = h; dir = d; mode = m; start = 1'b1; adv = with_adv;
        step();
        start = 1'b0; adv = 1'b0;
    endtask

    task automatic do_adv();
        adv = 1'b1;
        step();
        adv = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom); abort = 1'($urandom); adv = 1'($urandom);
            dir = 1'($urandom); mode = 2'($urandom);
            lo = ADDR_W'($urandom); hi = ADDR_W'($urandom);
            step();
        end
        total_cnt++;
        if ({addr, busy, done, err, last, cout} !== '0) $display("FAIL reset_outputs addr=%0d busy=%b done=%b err=%b last=%b cout=%b want all 0", addr, busy, done, err, last, cout);
        else pass_cnt++;
        start = 0; abort = 0; adv = 0; dir = 1; mode = 0; lo = 0; hi = 0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_linear_up();
        do_start(5, 7, 1'b1, 2'b00, 1'b0);
        total_cnt++;
        if (addr !== 10'd5 || busy !== 1'b1 || last !== 1'b0) $display("FAIL lin_start addr=%0d busy=%b last=%b want 5 1 0", addr, busy, last);
        else pass_cnt++;
        do_adv();
        total_cnt++;
        if (addr !== 10'd6 || last !== 1'b0) $display("FAIL lin_adv1 addr=%0d last=%b want 6 0", addr, last);
        else pass_cnt++;
        do_adv();
        total_cnt++;
        if (addr !== 10'd7 || last !== 1'b1) $display("FAIL lin_adv2 addr=%0d last=%b want 7 1", addr, last);
        else pass_cnt++;
        do_adv();
        total_cnt++;
        if (done !== 1'b1 || cout !== 1'b0 || busy !== 1'b0 || addr !== 10'd7) $display("FAIL lin_done done=%b cout=%b busy=%b addr=%0d want 1 0 0 7", done, cout, busy, addr);
        else pass_cnt++;
        step();
        total_cnt++;
        if (done !== 1'b0 || addr !== 10'd7) $display("FAIL lin_done_pulse done=%b addr=%0d want 0 7", done, addr);
        else pass_cnt++;
    endtask

    task automatic test_full_down();
        do_start(0, 1023, 1'b0, 2'b00, 1'b0);
        total_cnt++;
        if (addr !== 10'd1023 || busy !== 1'b1) $display("FAIL full_start addr=%0d busy=%b want 1023 1", addr, busy);
        else pass_cnt++;
        adv = 1'b1;
        repeat (1023) @(posedge clk);
        #1;
        total_cnt++;
        if (addr !== 10'd0 || last !== 1'b1 || done !== 1'b0) $display("FAIL full_bottom addr=%0d last=%b done=%b want 0 1 0", addr, last, done);
        else pass_cnt++;
        step();
        adv = 1'b0;
        total_cnt++;
        if (done !== 1'b1 || cout !== 1'b1 || busy !== 1'b0) $display("FAIL full_done done=%b cout=%b busy=%b want 1 1 0", done, cout, busy);
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if (addr !== 10'd0 || done !== 1'b0 || cout !== 1'b0) $display("FAIL full_idle addr=%0d done=%b cout=%b want 0 0 0", addr, done, cout);
        else pass_cnt++;
    endtask

    task automatic test_gray();
        do_start(2, 4, 1'b1, 2'b01, 1'b0);
        total_cnt++;
        if (addr !== 10'd3) $display("FAIL gray_0 addr=%0d want 3", addr);
        else pass_cnt++;
        do_adv();
        total_cnt++;
        if (addr !== 10'd2) $display("FAIL gray_1 addr=%0d want 2", addr);
        else pass_cnt++;
        do_adv();
        total_cnt++;
        if (addr !== 10'd6 || last !== 1'b1) $display("FAIL gray_2 addr=%0d last=%b want 6 1", addr, last);
        else pass_cnt++;
        do_adv();
    endtask

    task automatic test_rowfast();
        do_start(0, 2, 1'b1, 2'b10, 1'b0);
        total_cnt++;
        if (addr !== 10'd0) $display("FAIL row_0 addr=%0d want 0", addr);
        else pass_cnt++;
        do_adv();
        total_cnt++;
        if (addr !== 10'd32) $display("FAIL row_1 addr=%0d want 32", addr);
        else pass_cnt++;
        do_adv();
        total_cnt++;
        if (addr !== 10'd64 || last !== 1'b1) $display("FAIL row_2 addr=%0d last=%b want 64 1", addr, last);
        else pass_cnt++;
        do_adv();
    endtask

    task automatic test_config_err();
        do_start(9, 3, 1'b1, 2'b00, 1'b0);
        total_cnt++;
        if (err !== 1'b1 || busy !== 1'b0 || addr !== 10'd64) $display("FAIL cfg_err err=%b busy=%b addr=%0d want 1 0 64", err, busy, addr);
        else pass_cnt++;
        do_start(0, 5, 1'b1, 2'b11, 1'b0);
        total_cnt++;
        if (err !== 1'b1 || busy !== 1'b0) $display("FAIL cfg_rsvd err=%b busy=%b want 1 0", err, busy);
        else pass_cnt++;
        do_start(9, 9, 1'b1, 2'b00, 1'b0);
        total_cnt++;
        if (err !== 1'b0 || addr !== 10'd9 || last !== 1'b1 || busy !== 1'b1) $display("FAIL cfg_lo_eq_hi err=%b addr=%0d last=%b busy=%b want 0 9 1 1", err, addr, last, busy);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        abort = 1'b1; adv = 1'b1;
        step();
        abort = 1'b0; adv = 1'b0;
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || addr !== 10'd9) $display("FAIL abort_at_last done=%b busy=%b addr=%0d want 0 0 9", done, busy, addr);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_start(0, 10, 1'b1, 2'b00, 1'b0);
        repeat (6) do_adv();
        total_cnt++;
        if (addr !== 10'd6) $display("FAIL restart_pre addr=%0d want 6", addr);
        else pass_cnt++;
        do_start(100, 200, 1'b1, 2'b00, 1'b1);
        total_cnt++;
        if (addr !== 10'd100 || busy !== 1'b1) $display("FAIL restart_run addr=%0d busy=%b want 100 1", addr, busy);
        else pass_cnt++;
        do_start(50, 50, 1'b1, 2'b00, 1'b0);
        do_start(60, 70, 1'b0, 2'b00, 1'b1);
        total_cnt++;
        if (done !== 1'b0 || addr !== 10'd70 || busy !== 1'b1) $display("FAIL restart_vs_done done=%b addr=%0d busy=%b want 0 70 1", done, addr, busy);
        else pass_cnt++;
        lo = 0; hi = 1000; dir = 1'b1; mode = 2'b01;
        do_adv();
        total_cnt++;
        if (addr !== 10'd69) $display("FAIL cfg_change_ignored addr=%0d want 69", addr);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_start(300, 400, 1'b1, 2'b00, 1'b0);
        total_cnt++;
        if (addr !== 10'd300 || busy !== 1'b1) $display("FAIL areset_pre addr=%0d busy=%b want 300 1", addr, busy);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({addr, busy, done, err, last, cout} !== '0) $display("FAIL areset_mid addr=%0d busy=%b done=%b err=%b last=%b cout=%b want all 0", addr, busy, done, err, last, cout);
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        start = 0; abort = 0; adv = 0; dir = 1; mode = 0; lo = 0; hi = 0; rst_n = 0;
        test_reset();
        test_linear_up();
        test_full_down();
        test_gray();
        test_rowfast();
        test_config_err();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mbist_addr_gen.md
Name: mbist_addr_gen

Overview:
Parametrised address sequencer for the MBIST March engine. It is the successor to the plain up/down load counter. It adds programmable low/high bounds, a start/advance/done handshake, and three address orderings: linear, Gray-coded, and row-fast. The controller FSM drives `start`/`adv` and receives `addr` for the memory under test, plus `last`/`done` to step March elements.

Parameters:
ADDR_W, 10, address/counter width in bits (>=2)
ROW_W, 5, width of row field used by row-fast ordering (1..ADDR_W-1)

Ports:
clk      in   1       rising-edge clock
rst_n    in   1       asynchronous active-low reset
start    in   1       1-cycle pulse: sample lo/hi/dir/mode, begin sequence
abort    in   1       synchronous stop, return to IDLE
adv      in   1       advance one address (count enable) while busy
dir      in   1       1 = ascending (lo->hi), 0 = descending (hi->lo)
mode     in   2       00 linear, 01 Gray, 10 row-fast, 11 reserved
lo       in   ADDR_W  lower bound, inclusive
hi       in   ADDR_W  upper bound, inclusive
addr     out  ADDR_W  registered mapped address to memory
busy     out  1       sequence active
last     out  1       current addr is terminal address of the range
done     out  1       1-cycle pulse: adv taken on terminal address
cout     out  1       1-cycle pulse with done when terminal count is 2^ADDR_W-1 (up) or 0 (down)
err      out  1       sticky config error, cleared by next valid start

Behaviour:
- Reset (async, rst_n=0): state IDLE; cnt=0; addr=0; busy=0; last=0; done=0; cout=0; err=0; dir_q=1; mode_q=00.
- State IDLE, busy=0:
  - On start, sample lo/hi/dir/mode into lo_q/hi_q/dir_q/mode_q.
  - If lo>hi or mode==11: set err=1, stay IDLE, leave cnt/addr unchanged.
  - Otherwise: err=0, cnt <= dir ? lo : hi, then go to RUN.
  - Latency: addr valid and busy=1 on the cycle after start.
- State RUN, busy=1:
  - last = (dir_q ? cnt==hi_q : cnt==lo_q), combinational from registers.
  - adv & !last: cnt <= cnt +/- 1.
  - adv & last: done=1 and cout as defined for one cycle; go to IDLE; cnt/addr hold the terminal value.
  - No adv: hold.
  - lo==hi: last=1 on the first RUN cycle.
- Address mapping, applied to the next cnt so addr is registered on the same edge as cnt:
  - 00: addr = cnt.
  - 01: addr = cnt ^ (cnt>>1).
  - 10: addr = cnt rotated left by ROW_W.
  - Bounds and last always compare the internal cnt, never addr.
- Arithmetic: ADDR_W-bit modular. Wrap cannot occur inside a valid range, because lo<=hi and the sequence stops at the bound.
- Simultaneous events:
  - abort has priority over everything: IDLE next cycle, busy=0, no done, addr holds.
  - start in RUN (without abort) restarts with the newly sampled config; any pending adv is ignored that cycle.
  - start and the done-producing adv in the same cycle: restart wins, done is not asserted.
  - lo/hi/dir/mode changes during RUN have no effect (sampled values only).
- rst_n low mid-sequence: immediate return to reset values, regardless of clk.

Decomposition:
- Package mbist_pkg holds:
  - typedef enum logic [1:0] {ORD_LINEAR, ORD_GRAY, ORD_ROWFAST, ORD_RSVD} addr_order_e
  - typedef enum logic [1:0] {AG_IDLE, AG_RUN} ag_state_e
  - Shared by the March controller.
- One natural sub-module: mbist_addr_map. Purely combinational mapping (cnt, mode_q) -> address, parametrised by ADDR_W/ROW_W; reused by the data-background generator.
- Counter and FSM stay in mbist_addr_gen.

Test Plan (ADDR_W=10, ROW_W=5):
- Reset: hold rst_n=0 with random inputs -> addr=0, busy=0, done=0, err=0. Drop rst_n mid-RUN (cnt=300) -> all outputs 0 without a clk edge.
- Linear up, lo=5 hi=7 dir=1: start -> addr=5, busy=1; adv x2 -> 6, 7 with last=1 at 7; adv -> done=1 for one cycle, cout=0, busy=0, addr holds 7.
- Full-range down, lo=0 hi=1023 dir=0: start -> addr=1023; 1023 advs -> addr=0, last=1; adv -> done=1 and cout=1 for one cycle. Idle cycles without adv leave addr unchanged.
- Gray up, lo=2 hi=4: start -> addr=3; adv -> 2; adv -> 6 (last=1).
- Row-fast up, lo=0 hi=2: addr=0, 32, 64.
- Config errors and overrides:
  - lo=9 hi=3 start -> err=1, busy=0. Then lo=hi=9 start -> err=0, addr=9, last=1 immediately.
  - abort together with adv at last -> no done, busy=0.
  - start during RUN at cnt=6 with lo=100 -> addr=100.
